// File: rtl/imuldiv_mul_arbiter.sv
// Two-port round-robin front end for one shared iterative 32x32 signed multiplier.
// One operation in flight; operands are latched so the multiplier sees them stable until its response.
module imuldiv_mul_arbiter #(
    parameter int OP_W  = 32,
    parameter int RES_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic [OP_W-1:0]  req0_msg_a,
    input  logic [OP_W-1:0]  req0_msg_b,
    input  logic             req0_val,
    output logic             req0_rdy,
    output logic [RES_W-1:0] resp0_msg_result,
    output logic             resp0_val,
    input  logic             resp0_rdy,

    input  logic [OP_W-1:0]  req1_msg_a,
    input  logic [OP_W-1:0]  req1_msg_b,
    input  logic             req1_val,
    output logic             req1_rdy,
    output logic [RES_W-1:0] resp1_msg_result,
    output logic             resp1_val,
    input  logic             resp1_rdy,

    output logic [OP_W-1:0]  mulreq_msg_a,
    output logic [OP_W-1:0]  mulreq_msg_b,
    output logic             mulreq_val,
    input  logic             mulreq_rdy,
    input  logic [RES_W-1:0] mulresp_msg_result,
    input  logic             mulresp_val,
    output logic             mulresp_rdy,

    output logic             busy,
    output logic             owner
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [RES_W-1:0] result;
    logic             prio;
    logic             grant0;
    logic             grant1;

    // prio names the port that wins when both request in the same IDLE cycle
    assign grant0 = req0_val & (~req1_val | ~prio);
    assign grant1 = req1_val & (~req0_val |  prio);

    assign req0_rdy = (state == ST_IDLE) & grant0;
    assign req1_rdy = (state == ST_IDLE) & grant1;

    assign mulreq_msg_a     = op_a;
    assign mulreq_msg_b     = op_b;
    assign resp0_msg_result = result;
    assign resp1_msg_result = result;

    // Handshake outputs are registered alongside the state so they never glitch on input changes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            prio        <= 1'b0;
            owner       <= 1'b0;
            mulreq_val  <= 1'b0;
            mulresp_rdy <= 1'b0;
            resp0_val   <= 1'b0;
            resp1_val   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_val && req0_rdy) begin
                        op_a       <= req0_msg_a;
                        op_b       <= req0_msg_b;
                        owner      <= 1'b0;
                        prio       <= 1'b1;
                        state      <= ST_ISSUE;
                        mulreq_val <= 1'b1;
                        busy       <= 1'b1;
                    end else if (req1_val && req1_rdy) begin
                        op_a       <= req1_msg_a;
                        op_b       <= req1_msg_b;
                        owner      <= 1'b1;
                        prio       <= 1'b0;
                        state      <= ST_ISSUE;
                        mulreq_val <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (mulreq_rdy) begin
                        state       <= ST_WAIT;
                        mulreq_val  <= 1'b0;
                        mulresp_rdy <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mulresp_val) begin
                        result      <= mulresp_msg_result;
                        state       <= ST_RESP;
                        mulresp_rdy <= 1'b0;
                        resp0_val   <= ~owner;
                        resp1_val   <= owner;
                    end
                end
                ST_RESP: begin
                    if (owner ? resp1_rdy : resp0_rdy) begin
                        state     <= ST_IDLE;
                        resp0_val <= 1'b0;
                        resp1_val <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Scoreboard bench for imuldiv_mul_arbiter with a 33-cycle iterative multiplier model.
module tb_imuldiv_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] req0_msg_a = '0, req0_msg_b = '0, req1_msg_a = '0, req1_msg_b = '0;
    logic        req0_val = 1'b0, req1_val = 1'b0, req0_rdy, req1_rdy;
    logic [63:0] resp0_msg_result, resp1_msg_result;
    logic        resp0_val, resp1_val;
    logic        resp0_rdy = 1'b1, resp1_rdy = 1'b1;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulreq_rdy, mulresp_val, mulresp_rdy;
    logic [63:0] mulresp_msg_result;
    logic        busy, owner;

    imuldiv_mul_arbiter #(.OP_W(32), .RES_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
        .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
        .mulresp_rdy(mulresp_rdy), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Multiplier model: result appears 33 cycles after the request handshake, computed from the
    // live operand bus so any operand instability corrupts the product.
    logic        m_busy;
    int          m_cnt;
    logic signed [63:0] ext_a, ext_b;
    assign ext_a = {{32{mulreq_msg_a[31]}}, mulreq_msg_a};
    assign ext_b = {{32{mulreq_msg_b[31]}}, mulreq_msg_b};
    assign mulreq_rdy  = ~m_busy;
    assign mulresp_val = m_busy && (m_cnt == 33);
    assign mulresp_msg_result = ext_a * ext_b;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (mulreq_val) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
            end
        end else if (m_cnt < 33) begin
            m_cnt <= m_cnt + 1;
        end else if (mulresp_rdy) begin
            m_busy <= 1'b0;
        end
    end

    typedef struct {
        int          port;
        logic [63:0] res;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   last_acc;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mon_port(input int p, input logic v, input logic r, input logic o,
                            input logic [63:0] m, input logic pv);
        exp_t e;
        if (v && !pv) begin
            chk("resp_other_low", {63'd0, o}, 64'd0);
            if (sb.size() == 0) chk("resp_unexpected_rise", 64'd1, 64'd0);
            else chk("resp_latency", 64'(cyc - sb[0].acc), 64'd35);
        end
        if (v && r) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_port", 64'(p), 64'(e.port));
                chk("resp_result", m, e.res);
            end
        end
    endtask

    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            mon_port(0, resp0_val, resp0_rdy, resp1_val, resp0_msg_result, prev0);
            mon_port(1, resp1_val, resp1_rdy, resp0_val, resp1_msg_result, prev1);
        end
        prev0 = resp0_val;
        prev1 = resp1_val;
    end

    task automatic drive(input int p, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin req0_val = v; req0_msg_a = a; req0_msg_b = b; end
        else        begin req1_val = v; req1_msg_a = a; req1_msg_b = b; end
    endtask

    // Called at posedge+#1; returns at posedge+#1 of the cycle after acceptance with operands scrambled.
    task automatic send(input int p, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        exp_t e;
        bit   done = 1'b0;
        drive(p, 1'b1, a, b);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if ((p == 0) ? req0_rdy : req1_rdy) begin
                e.port = p; e.res = exp; e.acc = cyc;
                sb.push_back(e);
                grant_log.push_back(p);
                last_acc = cyc;
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        drive(p, 1'b0, $urandom, $urandom);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int bad;
        int h;

        // Reset values; ready still follows the grant logic while in reset
        req1_val = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mulreq_val", {63'd0, mulreq_val}, 64'd0);
        chk("rst_mulresp_rdy", {63'd0, mulresp_rdy}, 64'd0);
        chk("rst_resp_val", {62'd0, resp1_val, resp0_val}, 64'd0);
        chk("rst_owner", {63'd0, owner}, 64'd0);
        chk("rst_operands", {mulreq_msg_a, mulreq_msg_b}, 64'd0);
        chk("rst_result", resp0_msg_result, 64'd0);
        chk("rst_rdy", {62'd0, req1_rdy, req0_rdy}, 64'd2);
        req1_val = 1'b0;
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Single op on port 0
        send(0, 32'd7, -32'sd3, 64'hFFFFFFFF_FFFFFFEB);
        drain();

        // Simultaneous requests with prio=0
        do_reset();
        grant_log.delete();
        fork
            send(0, 32'd2, 32'd3, 64'd6);
            send(1, -32'sd4, 32'd5, 64'hFFFFFFFF_FFFFFFEC);
        join
        drain();
        chk("tie_first", 64'(grant_log[0]), 64'd0);
        chk("tie_second", 64'(grant_log[1]), 64'd1);

        // Continuous requests: strict alternation
        grant_log.delete();
        fork
            begin
                send(0, 32'd3, 32'd4, 64'd12);
                send(0, -32'sd5, 32'd6, 64'hFFFFFFFF_FFFFFFE2);
                send(0, 32'h7FFFFFFF, 32'd2, 64'h00000000_FFFFFFFE);
            end
            begin
                send(1, 32'd10, 32'd10, 64'd100);
                send(1, -32'sd8, -32'sd8, 64'd64);
                send(1, 32'h00010000, 32'h00010000, 64'h00000001_00000000);
            end
        join
        drain();
        chk("alt_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("alt_order", 64'(grant_log[i]), 64'(i % 2));

        // Response backpressure on port 1 while port 0 waits
        resp1_rdy = 1'b0;
        send(1, 32'd100, -32'sd7, 64'hFFFFFFFF_FFFFFD44);
        bad = 1;
        for (int i = 0; i < 60 && bad == 1; i++) begin
            @(negedge clk);
            if (resp1_val) bad = 0;
        end
        chk("hold_resp_seen", 64'(bad), 64'd0);
        @(posedge clk); #1;
        h = 0;
        fork
            send(0, 32'd12, 32'd12, 64'd144);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (!resp1_val || resp0_val || req0_rdy || !owner ||
                        resp1_msg_result != 64'hFFFFFFFF_FFFFFD44) h++;
                end
                chk("hold_stable", 64'(h), 64'd0);
                @(posedge clk); #1;
                resp1_rdy = 1'b1;
                h = cyc;
            end
        join
        chk("hold_release_accept", 64'(last_acc), 64'(h + 1));
        drain();

        // Operand stability after acceptance
        send(0, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (mulreq_msg_a != 32'h80000000 || mulreq_msg_b != 32'h80000000) bad++;
        end
        chk("mulreq_stable", 64'(bad), 64'd0);
        drain();

        // Reset during WAIT aborts the operation
        send(0, 32'd9, 32'd9, 64'd81);
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_mulresp_rdy", {63'd0, mulresp_rdy}, 64'd0);
        chk("abort_resp_val", {62'd0, resp1_val, resp0_val}, 64'd0);
        chk("abort_operands", {mulreq_msg_a, mulreq_msg_b}, 64'd0);
        sb.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (resp0_val || resp1_val || busy) bad++;
        end
        chk("abort_no_resp", 64'(bad), 64'd0);
        @(posedge clk); #1;
        send(1, 32'h12345678, 32'd2, 64'h00000000_2468ACF0);
        drain();

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
